mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 192 +++++++++++++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding, fixed-latency block memory model.
//
// A request is accepted only while idle. It is held for LATENCY cycles and then
// answered with exactly one of three one-cycle pulses: read data valid, write
// committed, or error. Requests that arrive while a transaction is in flight
// are ignored, not queued.
//
// On reset every 32-bit word of the array is loaded with its own byte address,
// so reads return a recognisable pattern before anything has been written.
//
// Ports:
//   clk          - clock; all state changes on the rising edge
//   rst          - asynchronous active-high reset; aborts any transaction
//   mem_addr     - byte address; bits [5:0] are ignored (block-aligned)
//   mem_rd_en    - read request
//   mem_wr_en    - write request (both high together is an illegal request)
//   mem_wr_blk   - write block data
//   mem_rd_blk   - registered read data; word k is bits [32k+31:32k]
//   mem_ready    - high while idle, i.e. a request can be accepted
//   mem_rd_valid - one-cycle pulse, mem_rd_blk carries fresh read data
//   mem_wr_done  - one-cycle pulse, write has been committed to the array
//   mem_err      - one-cycle pulse, request was illegal or out of range
module mem_responder #(
    parameter int unsigned PA_WIDTH   = 32,
    parameter int unsigned BLK_WIDTH  = 512,
    parameter int unsigned DEPTH_BLKS = 16,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PA_WIDTH-1:0]  mem_addr,
    input  logic                 mem_rd_en,
    input  logic                 mem_wr_en,
    input  logic [BLK_WIDTH-1:0] mem_wr_blk,
    output logic [BLK_WIDTH-1:0] mem_rd_blk,
    output logic                 mem_ready,
    output logic                 mem_rd_valid,
    output logic                 mem_wr_done,
    output logic                 mem_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_BLKS);
    localparam int unsigned WORDS = BLK_WIDTH / 32;
    // One past the last valid byte address; one bit wider than the address so
    // the limit itself is representable for any PA_WIDTH.
    localparam logic [PA_WIDTH:0] ADDR_LIMIT = (PA_WIDTH + 1)'(DEPTH_BLKS * 64);
    localparam logic [3:0]        CNT_INIT   = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Request captured at accept time.
    logic                 is_wr_q;
    logic                 bad_q;
    logic [IDX_W-1:0]     idx_q;
    logic [BLK_WIDTH-1:0] wr_blk_q;

    logic [BLK_WIDTH-1:0] blocks_q [DEPTH_BLKS];

    logic [BLK_WIDTH-1:0] rd_blk_q;
    logic                 rd_valid_q;
    logic                 wr_done_q;
    logic                 err_q;

    logic             req_any;
    logic             req_both;
    logic             out_of_range;
    logic             accept;
    logic             resp_entry;
    logic [IDX_W-1:0] req_idx;

    assign req_any      = mem_rd_en | mem_wr_en;
    assign req_both     = mem_rd_en & mem_wr_en;
    assign out_of_range = {1'b0, mem_addr} >= ADDR_LIMIT;
    assign req_idx      = mem_addr[6+IDX_W-1:6];
    // An illegal (both-enables) request is still accepted; it is answered with
    // an error after the normal latency.
    assign accept       = (state_q == StIdle) && req_any;
    // The edge that moves BUSY -> RESP is the one that commits/responds.
    assign resp_entry   = (state_q == StBusy) && (cnt_q == 4'd0);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    state_d = StBusy;
                    cnt_d   = CNT_INIT;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_wr_q  <= 1'b0;
            bad_q    <= 1'b0;
            idx_q    <= '0;
            wr_blk_q <= '0;
        end else if (accept) begin
            is_wr_q  <= mem_wr_en;
            bad_q    <= req_both | out_of_range;
            idx_q    <= req_idx;
            wr_blk_q <= mem_wr_blk;
        end
    end

    // ------------------------------------------------------------------
    // Block storage; reset loads each word with its own byte address.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < int'(DEPTH_BLKS); b++) begin
                for (int k = 0; k < int'(WORDS); k++) begin
                    blocks_q[b][32*k +: 32] <= 32'(b * 64 + 4 * k);
                end
            end
        end else if (resp_entry && !bad_q && is_wr_q) begin
            blocks_q[idx_q] <= wr_blk_q;
        end
    end

    // ------------------------------------------------------------------
    // Response: pulses are registered so they are high for the RESP cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_blk_q   <= '0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            err_q      <= 1'b0;
            if (resp_entry) begin
                if (bad_q) begin
                    err_q <= 1'b1;
                end else if (is_wr_q) begin
                    wr_done_q <= 1'b1;
                end else begin
                    rd_valid_q <= 1'b1;
                    rd_blk_q   <= blocks_q[idx_q];
                end
            end
        end
    end

    assign mem_rd_blk   = rd_blk_q;
    assign mem_ready    = (state_q == StIdle);
    assign mem_rd_valid = rd_valid_q;
    assign mem_wr_done  = wr_done_q;
    assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model (word array plus
// "accepted at edge N, answered at edge N+LATENCY, free again at N+LATENCY+1").
module tb_mem_responder;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  mem_addr = '0;
    logic         mem_rd_en = 1'b0;
    logic         mem_wr_en = 1'b0;
    logic [511:0] mem_wr_blk = '0;
    logic [511:0] mem_rd_blk;
    logic         mem_ready;
    logic         mem_rd_valid;
    logic         mem_wr_done;
    logic         mem_err;

    always #5 clk = ~clk;

    mem_responder #(
        .PA_WIDTH   (32),
        .BLK_WIDTH  (512),
        .DEPTH_BLKS (16),
        .LATENCY    (L)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_blk   (mem_wr_blk),
        .mem_rd_blk   (mem_rd_blk),
        .mem_ready    (mem_ready),
        .mem_rd_valid (mem_rd_valid),
        .mem_wr_done  (mem_wr_done),
        .mem_err      (mem_err)
    );

    int checks = 0;
    int errors = 0;
    int phase  = 0;

    // ---------------- reference model ----------------
    logic [31:0]  m_mem [16][16];
    logic [511:0] m_rd_blk = '0;
    bit           m_ready = 1'b1;
    bit           m_rv = 1'b0, m_wd = 1'b0, m_err = 1'b0;
    bit           pend = 1'b0;
    int           edge_n = 0, resp_edge = 0, next_free = 0;
    bit           p_wr, p_bad;
    int           p_idx;
    logic [511:0] p_data;

    function automatic logic [511:0] blk_of(input int b);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = m_mem[b][k];
        return r;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            for (int b = 0; b < 16; b++)
                for (int k = 0; k < 16; k++) m_mem[b][k] = 32'(b * 64 + k * 4);
            m_rd_blk  = '0;
            pend      = 1'b0;
            next_free = 0;
            m_ready   = 1'b1;
            m_rv = 1'b0; m_wd = 1'b0; m_err = 1'b0;
        end else begin
            m_rv = 1'b0; m_wd = 1'b0; m_err = 1'b0;
            if (pend && edge_n == resp_edge) begin
                pend = 1'b0;
                if (p_bad) m_err = 1'b1;
                else if (p_wr) begin
                    for (int k = 0; k < 16; k++) m_mem[p_idx][k] = p_data[32*k +: 32];
                    m_wd = 1'b1;
                end else begin
                    m_rd_blk = blk_of(p_idx);
                    m_rv = 1'b1;
                end
            end
            if (m_ready && (mem_rd_en || mem_wr_en)) begin
                pend      = 1'b1;
                p_wr      = mem_wr_en;
                p_bad     = (mem_rd_en && mem_wr_en) || (mem_addr >= 32'h400);
                p_idx     = int'(mem_addr[9:6]);
                p_data    = mem_wr_blk;
                resp_edge = edge_n + L;
                next_free = edge_n + L + 1;
            end
            m_ready = (edge_n >= next_free);
        end
    end

    // ---------------- compare ----------------
    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", 512'(mem_ready), 512'(1'b1));
            chk("rst_rd_valid", 512'(mem_rd_valid), 512'(1'b0));
            chk("rst_wr_done", 512'(mem_wr_done), 512'(1'b0));
            chk("rst_err", 512'(mem_err), 512'(1'b0));
            chk("rst_rd_blk", mem_rd_blk, 512'(0));
        end else begin
            chk("ready", 512'(mem_ready), 512'(m_ready));
            chk("rd_valid", 512'(mem_rd_valid), 512'(m_rv));
            chk("wr_done", 512'(mem_wr_done), 512'(m_wd));
            chk("err", 512'(mem_err), 512'(m_err));
            chk("rd_blk", mem_rd_blk, m_rd_blk);
            // Hand-computed values that pin the model itself.
            if (m_rv) begin
                case (phase)
                    1: begin
                        chk("lit_rd40_w0", 512'(mem_rd_blk[31:0]), 512'(32'h40));
                        chk("lit_rd40_w15", 512'(mem_rd_blk[511:480]), 512'(32'h7C));
                    end
                    3: begin
                        chk("lit_rd80_w0", 512'(mem_rd_blk[31:0]), 512'(32'hA5A5A5A5));
                        chk("lit_rd80_w15", 512'(mem_rd_blk[511:480]), 512'(32'hA5A5A5A5));
                    end
                    4: begin
                        chk("lit_rdC0_w0", 512'(mem_rd_blk[31:0]), 512'(32'hC0));
                        chk("lit_rdC0_w15", 512'(mem_rd_blk[511:480]), 512'(32'hFC));
                    end
                    5: begin
                        chk("lit_rd00_w1", 512'(mem_rd_blk[63:32]), 512'(32'h04));
                        chk("lit_rd00_w15", 512'(mem_rd_blk[511:480]), 512'(32'h3C));
                    end
                    8: chk("lit_rd40_again_w1", 512'(mem_rd_blk[63:32]), 512'(32'h44));
                    10: begin
                        chk("lit_abort_w0", 512'(mem_rd_blk[31:0]), 512'(32'h0));
                        chk("lit_abort_w15", 512'(mem_rd_blk[511:480]), 512'(32'h3C));
                    end
                    default: ;
                endcase
            end
            if (m_err && (phase == 6 || phase == 7)) begin
                chk("lit_err_no_rv", 512'(mem_rd_valid), 512'(1'b0));
                chk("lit_err_hold_w15", 512'(mem_rd_blk[511:480]), 512'(32'h3C));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [511:0] d, input int hold);
        mem_rd_en  = rd;
        mem_wr_en  = wr;
        mem_addr   = a;
        mem_wr_blk = d;
        idle(hold);
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
    endtask

    function automatic logic [511:0] fill(input logic [31:0] w);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = w;
        return r;
    endfunction

    initial begin
        logic [511:0] rnd_blk;
        int           op;
        idle(3);
        rst = 1'b0;

        phase = 1; req(1, 0, 32'h40, '0, 1);              idle(L + 1);
        phase = 2; req(0, 1, 32'h80, fill(32'hA5A5A5A5), 1); idle(L + 1);
        phase = 3; req(1, 0, 32'h80, '0, 1);              idle(L + 1);
        phase = 4; req(1, 0, 32'hC0, '0, 1);              idle(L + 1);
        // Second read is driven while busy and must be ignored.
        phase = 5; req(1, 0, 32'h00, '0, 1); req(1, 0, 32'h40, '0, 3); idle(L);
        phase = 6; req(1, 0, 32'h400, '0, 1);             idle(L + 1);
        phase = 7; req(1, 1, 32'h40, fill(32'h12345678), 1); idle(L + 1);
        phase = 8; req(1, 0, 32'h40, '0, 1);              idle(L + 1);
        // Write aborted by reset in BUSY.
        phase = 9; req(0, 1, 32'h00, fill(32'hFFFFFFFF), 1);
        idle(1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        phase = 10; req(1, 0, 32'h00, '0, 1);             idle(L + 1);

        phase = 0;
        for (int i = 0; i < 1500; i++) begin
            op = int'($urandom_range(0, 9));
            for (int k = 0; k < 16; k++) rnd_blk[32*k +: 32] = $urandom;
            mem_wr_blk = rnd_blk;
            mem_addr   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1151));
            mem_rd_en  = (op <= 3) || (op == 7);
            mem_wr_en  = (op >= 4 && op <= 7);
            rst        = ($urandom_range(0, 299) == 0);
            idle(1);
        end
        rst       = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        idle(L + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
